// File: rtl/cache_l2_pkg.sv
// Shared types and defaults for the L1-to-L2 miss bridge.
// The optional response timeout is enabled with the CACHE_L2_TIMEOUT_EN macro.
package cache_l2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } l2_state_e;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_OFFSET_W = 4;
    localparam int DEF_INDEX_W  = 6;
    localparam int DEF_TIMEOUT  = 255;

    // Builds {tag, index, zero offset}; callers keep the low ADDR_W bits.
    function automatic logic [63:0] line_addr(input logic [63:0] tag,
                                              input logic [63:0] index,
                                              input int          index_w,
                                              input int          offset_w);
        line_addr = (tag << (index_w + offset_w)) | (index << offset_w);
    endfunction

endpackage

// File: rtl/cache_l2_timer.sv
// Response timeout counter for the L2 bridge (used only with CACHE_L2_TIMEOUT_EN).
// Expiry fires combinationally in the TIMEOUT-th counted cycle so the FSM can leave on that edge.
module cache_l2_timer
    import cache_l2_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear on a new transaction, saturate at TIMEOUT.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_en_i && (count_q != CNT_W'(TIMEOUT))) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = count_en_i && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/cache_l2_bridge.sv
// Turns held read_l2/write_l2 miss requests into single line-aligned L2 transactions.
// Optional response timeout: define CACHE_L2_TIMEOUT_EN.
module cache_l2_bridge
    import cache_l2_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int OFFSET_W = DEF_OFFSET_W,
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [ADDR_W-1:0]                  addr,
    input  logic [ADDR_W-INDEX_W-OFFSET_W-1:0] victim_tag,
    input  logic                               read_l2,
    input  logic                               write_l2,
    output logic                               l2_ack,
    output logic                               l2_err,
    output logic                               l2_busy,
    output logic                               l2_req_valid,
    input  logic                               l2_req_ready,
    output logic                               l2_req_write,
    output logic [ADDR_W-1:0]                  l2_req_addr,
    input  logic                               l2_rsp_valid,
    input  logic                               l2_rsp_err
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    l2_state_e         state_q, state_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              start_s;
    logic              expired_s;
    logic [63:0]       wb_line_s;
    logic [63:0]       fill_line_s;
    logic              unused_s;

    assign wb_line_s   = line_addr(64'(victim_tag), 64'(addr[OFFSET_W +: INDEX_W]),
                                   INDEX_W, OFFSET_W);
    assign fill_line_s = line_addr(64'(addr[ADDR_W-1 -: TAG_W]), 64'(addr[OFFSET_W +: INDEX_W]),
                                   INDEX_W, OFFSET_W);
    assign unused_s    = ^{addr[OFFSET_W-1:0], wb_line_s[63:ADDR_W], fill_line_s[63:ADDR_W]};

`ifdef CACHE_L2_TIMEOUT_EN
    cache_l2_timer #(
        .TIMEOUT    (TIMEOUT)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (start_s),
        .count_en_i ((state_q == ST_ISSUE) || (state_q == ST_WAIT)),
        .expired_o  (expired_s)
    );
`else
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = TIMEOUT;
    assign expired_s        = 1'b0;
`endif

    // Next state plus next registered outputs; writeback beats fill when both are held.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        write_d = write_q;
        addr_d  = addr_q;
        start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (write_l2) begin
                    state_d = ST_ISSUE;
                    write_d = 1'b1;
                    addr_d  = wb_line_s[ADDR_W-1:0];
                    start_s = 1'b1;
                end else if (read_l2) begin
                    state_d = ST_ISSUE;
                    write_d = 1'b0;
                    addr_d  = fill_line_s[ADDR_W-1:0];
                    start_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (expired_s) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else if (l2_req_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (l2_rsp_valid) begin
                    state_d = ST_DONE;
                    err_d   = l2_rsp_err;
                end else if (expired_s) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        valid_d = (state_d == ST_ISSUE);
        busy_d  = (state_d != ST_IDLE);
        ack_d   = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            write_q <= write_d;
            addr_q  <= addr_d;
        end
    end

    assign l2_ack       = ack_q;
    assign l2_err       = err_q;
    assign l2_busy      = busy_q;
    assign l2_req_valid = valid_q;
    assign l2_req_write = write_q;
    assign l2_req_addr  = addr_q;

endmodule

// File: tb/tb_cache_l2_bridge.sv
// Scoreboard bench for cache_l2_bridge: stimulus pushes expected requests/acks,
// a negedge monitor pops and compares on each L2 handshake and each l2_ack.
module tb_cache_l2_bridge;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
    } req_exp_t;

    typedef struct {
        logic err;
        int   cyc;
    } ack_exp_t;

`ifdef CACHE_L2_TIMEOUT_EN
    localparam int STALL = 4;
`else
    localparam int STALL = 7;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [21:0] victim_tag;
    logic        read_l2;
    logic        write_l2;
    logic        l2_ack;
    logic        l2_err;
    logic        l2_busy;
    logic        l2_req_valid;
    logic        l2_req_ready;
    logic        l2_req_write;
    logic [31:0] l2_req_addr;
    logic        l2_rsp_valid;
    logic        l2_rsp_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    req_exp_t req_q[$];
    ack_exp_t ack_q[$];

    cache_l2_bridge #(
        .ADDR_W       (32),
        .OFFSET_W     (4),
        .INDEX_W      (6),
        .TIMEOUT      (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .victim_tag   (victim_tag),
        .read_l2      (read_l2),
        .write_l2     (write_l2),
        .l2_ack       (l2_ack),
        .l2_err       (l2_err),
        .l2_busy      (l2_busy),
        .l2_req_valid (l2_req_valid),
        .l2_req_ready (l2_req_ready),
        .l2_req_write (l2_req_write),
        .l2_req_addr  (l2_req_addr),
        .l2_rsp_valid (l2_rsp_valid),
        .l2_rsp_err   (l2_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop expectations on each accepted request and each ack pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (l2_req_valid && l2_req_ready) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", 64'd1, 64'd0);
                end else begin
                    req_exp_t r;
                    r = req_q.pop_front();
                    check("req_write", 64'(l2_req_write), 64'(r.wr));
                    check("req_addr", 64'(l2_req_addr), 64'(r.addr));
                end
            end
            if (l2_ack) begin
                if (ack_q.size() == 0) begin
                    check("unexpected_ack", 64'd1, 64'd0);
                end else begin
                    ack_exp_t a;
                    a = ack_q.pop_front();
                    check("ack_err", 64'(l2_err), 64'(a.err));
                    check("ack_cycle", 64'(cyc), 64'(a.cyc));
                end
            end
        end
    end

    task automatic check_idle_outputs(input string name);
        check({name, "_ack"},   64'(l2_ack),       64'd0);
        check({name, "_err"},   64'(l2_err),       64'd0);
        check({name, "_busy"},  64'(l2_busy),      64'd0);
        check({name, "_valid"}, 64'(l2_req_valid), 64'd0);
        check({name, "_write"}, 64'(l2_req_write), 64'd0);
        check({name, "_addr"},  64'(l2_req_addr),  64'd0);
    endtask

    // Called in the first ISSUE cycle (#1 after edge 0); returns at negedge of the following IDLE cycle.
    task automatic serve(input int stall, input int delay, input logic err_bit, input logic pulse,
                         input logic exp_wr, input logic [31:0] exp_addr,
                         input logic drop_w, input logic drop_r);
        ack_exp_t a;
        a.err = err_bit;
        a.cyc = cyc + 2 + stall + delay;
        ack_q.push_back(a);
        for (int i = 0; i <= stall; i++) begin
            l2_req_ready = (i == stall);
            l2_rsp_valid = pulse && (i == 1);
            @(negedge clk);
            if (i == 0) check("issue_busy", 64'(l2_busy), 64'd1);
            check("issue_valid", 64'(l2_req_valid), 64'd1);
            check("issue_write", 64'(l2_req_write), 64'(exp_wr));
            check("issue_addr", 64'(l2_req_addr), 64'(exp_addr));
            @(posedge clk); #1;
        end
        l2_req_ready = 1'b0;
        for (int j = 0; j <= delay; j++) begin
            l2_rsp_valid = (j == delay);
            l2_rsp_err   = err_bit && (j == delay);
            @(posedge clk); #1;
        end
        l2_rsp_valid = 1'b0;
        l2_rsp_err   = 1'b0;
        @(posedge clk); #1;
        if (drop_w) write_l2 = 1'b0;
        if (drop_r) read_l2 = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(l2_busy), 64'd0);
        check("idle_ack", 64'(l2_ack), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        addr         = 32'h0;
        victim_tag   = 22'h0;
        read_l2      = 1'b0;
        write_l2     = 1'b0;
        l2_req_ready = 1'b0;
        l2_rsp_valid = 1'b0;
        l2_rsp_err   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Plain fill, immediate ready and response.
        read_l2 = 1'b1;
        addr    = 32'h0000_1234;
        req_q.push_back('{1'b0, 32'h0000_1230});
        @(posedge clk); #1;
        serve(0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_1230, 1'b0, 1'b1);

        // Writeback and fill both held: writeback first, then fill back to back.
        @(posedge clk); #1;
        write_l2   = 1'b1;
        read_l2    = 1'b1;
        victim_tag = 22'h0ABCDE;
        addr       = 32'h1234_5457;
        req_q.push_back('{1'b1, 32'h2AF3_7850});
        @(posedge clk); #1;
        serve(0, 0, 1'b0, 1'b0, 1'b1, 32'h2AF3_7850, 1'b1, 1'b0);
        req_q.push_back('{1'b0, 32'h1234_5450});
        @(posedge clk); #1;
        serve(0, 1, 1'b0, 1'b0, 1'b0, 32'h1234_5450, 1'b0, 1'b1);

        // Ready held low; stray response during ISSUE must be ignored.
        @(posedge clk); #1;
        read_l2 = 1'b1;
        addr    = 32'h0000_ABCF;
        req_q.push_back('{1'b0, 32'h0000_ABC0});
        @(posedge clk); #1;
        serve(STALL, 0, 1'b0, 1'b1, 1'b0, 32'h0000_ABC0, 1'b0, 1'b1);

        // Error response on a writeback at the top index.
        @(posedge clk); #1;
        write_l2   = 1'b1;
        victim_tag = 22'h000001;
        addr       = 32'hFFFF_FFFF;
        req_q.push_back('{1'b1, 32'h0000_07F0});
        @(posedge clk); #1;
        serve(0, 2, 1'b1, 1'b0, 1'b1, 32'h0000_07F0, 1'b1, 1'b0);

        // Reset in WAIT: outputs clear, late response yields no ack.
        @(posedge clk); #1;
        read_l2 = 1'b1;
        addr    = 32'h0000_0040;
        req_q.push_back('{1'b0, 32'h0000_0040});
        @(posedge clk); #1;
        l2_req_ready = 1'b1;
        @(posedge clk); #1;
        l2_req_ready = 1'b0;
        reset        = 1'b1;
        read_l2      = 1'b0;
        @(posedge clk); #1;
        reset        = 1'b0;
        l2_rsp_valid = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        @(posedge clk); #1;
        l2_rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("late_rsp_ack", 64'(l2_ack), 64'd0);
            check("late_rsp_busy", 64'(l2_busy), 64'd0);
        end

`ifdef CACHE_L2_TIMEOUT_EN
        // Timeout in ISSUE with no ready: abandoned, error ack after 8 counted cycles.
        @(posedge clk); #1;
        read_l2 = 1'b1;
        addr    = 32'h0000_0100;
        @(posedge clk); #1;
        ack_q.push_back('{1'b1, cyc + 8});
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        check("timeout_valid_drop", 64'(l2_req_valid), 64'd0);
        @(posedge clk); #1;
        read_l2 = 1'b0;

        // Response in the expiry cycle wins: no error.
        @(posedge clk); #1;
        read_l2 = 1'b1;
        addr    = 32'h0000_0200;
        req_q.push_back('{1'b0, 32'h0000_0200});
        @(posedge clk); #1;
        ack_q.push_back('{1'b0, cyc + 8});
        l2_req_ready = 1'b1;
        @(posedge clk); #1;
        l2_req_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        l2_rsp_valid = 1'b1;
        @(posedge clk); #1;
        l2_rsp_valid = 1'b0;
        @(posedge clk); #1;
        read_l2 = 1'b0;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("req_queue_drained", 64'(req_q.size()), 64'd0);
        check("ack_queue_drained", 64'(ack_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_l2_bridge.md
# cache_l2_bridge

Bridge between the L1 cache controller's miss-handling outputs and the L2 memory port. It turns the controller's level-held `read_l2` / `write_l2` requests into single line-aligned transactions on a valid/ready L2 request channel. It waits for the L2 response and returns a one-cycle `l2_ack` pulse. It sits directly downstream of `cache_controller` and supplies its `l2_ack` input.

## Interface
- `ADDR_W`, 32, byte address width
- `OFFSET_W`, 4, line offset bits (16-byte lines)
- `INDEX_W`, 6, set index bits; tag width = ADDR_W-INDEX_W-OFFSET_W
- `TIMEOUT`, 255, response timeout in cycles (used only with CACHE_L2_TIMEOUT_EN)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `addr` in ADDR_W: current access address from the controller (supplies tag and index for fills)
- `victim_tag` in TAG_W: tag of the dirty line being written back
- `read_l2` in 1: fill request, held until acked
- `write_l2` in 1: writeback request, held until acked
- `l2_ack` out 1: one-cycle completion pulse to the controller
- `l2_err` out 1: qualifies `l2_ack`; transaction failed
- `l2_busy` out 1: high in any state other than IDLE
- `l2_req_valid` out 1: L2 request valid
- `l2_req_ready` in 1: L2 accepts request
- `l2_req_write` out 1: 1 = writeback, 0 = fill
- `l2_req_addr` out ADDR_W: line-aligned address, offset bits zero
- `l2_rsp_valid` in 1: L2 completion
- `l2_rsp_err` in 1: L2 error, qualified by `l2_rsp_valid`

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE → ISSUE when `write_l2` or `read_l2` is sampled high.
  - If both are high, the writeback is served first.
  - Writeback address = {victim_tag, addr index, 0}.
  - Fill address = {addr tag, addr index, 0}.
  - Address and write flag are latched on this edge.
- ISSUE: `l2_req_valid`=1, with address and write flag held stable. Goes to WAIT on the edge where `l2_req_ready`=1.
- WAIT: waits for `l2_rsp_valid`. On response, goes to DONE and latches `l2_err` = `l2_rsp_err`. `l2_rsp_valid` is ignored in IDLE, ISSUE and DONE.
- DONE: `l2_ack`=1 for exactly one cycle, then IDLE.
- Requester rule: the served request line drops in the cycle after `l2_ack`. A still-high request is treated as a new transaction. This is how a write-then-read sequence is served back to back.
- Reset, including mid-transaction: FSM goes to IDLE. All outputs go to 0 and `l2_req_addr` to 0. The outstanding L2 response is discarded because it arrives in IDLE.

## Timing
- Request sampled at edge 0 → `l2_req_valid` high from cycle 1.
- Ready in cycle 1 → WAIT from cycle 2.
- Response in cycle k (k≥2) → `l2_ack` high in cycle k+1.
- Minimum request-to-ack latency: 3 cycles.
- Back-to-back transactions: at least 1 IDLE cycle between the `l2_ack` pulses.
- `l2_busy` is high from cycle 1 through the DONE cycle.

## Configuration
- Macro `CACHE_L2_TIMEOUT_EN`.
- Defined:
  - A counter of width clog2(TIMEOUT+1) clears on IDLE→ISSUE and counts each cycle in ISSUE or WAIT.
  - When the count reaches TIMEOUT, the FSM goes to DONE with `l2_err`=1. `l2_req_valid` drops (the transaction is abandoned).
  - If a response and the timeout land in the same cycle, the response wins and `l2_err` = `l2_rsp_err`.
- Undefined: no counter; WAIT and ISSUE last indefinitely; `l2_err` comes only from `l2_rsp_err`.

## Structure
- Package `cache_l2_pkg`:
  - FSM state enum
  - default ADDR_W, OFFSET_W, INDEX_W, TIMEOUT constants
  - `line_addr(tag, index)` function
- One sub-module, `cache_l2_timer` (counter plus expiry flag), instantiated only under `CACHE_L2_TIMEOUT_EN`.

## Test plan
- Reset for 10 cycles, then `read_l2`=1, addr=0x0000_1234, ready and response immediate → `l2_req_addr`=0x0000_1230, `l2_req_write`=0, `l2_ack` 3 cycles after the request, `l2_err`=0.
- `write_l2`=`read_l2`=1, victim_tag=0xABCDE, addr index 5 → writeback to {0xABCDE, 5, 0} acked first, then fill to the addr line. Exactly two `l2_ack` pulses.
- `l2_req_ready` held low for 7 cycles → `l2_req_valid` and address stable for all 8 ISSUE cycles; `l2_rsp_valid` pulsed during ISSUE is ignored.
- `l2_rsp_err`=1 with response → `l2_ack`=1 and `l2_err`=1 in the same cycle. Reset asserted in WAIT → next cycle all outputs 0; a late response produces no ack.
- With `CACHE_L2_TIMEOUT_EN` and TIMEOUT=8, no response → `l2_ack` and `l2_err` in the cycle after 8 counted cycles. Response in the expiry cycle → `l2_err`=0.
